// File: rtl/hazard3_bus_pkg.sv
// Shared AHB-Lite encodings for the hazard3 bus fabric.
// Transfer types, burst type and arbitration mode selectors.
package hazard3_bus_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/hazard3_rr_priority_sel.sv
// One-hot priority select: first set request at or above start,
// wrapping from N-1 back to 0. Start of zero gives fixed priority.
module hazard3_rr_priority_sel #(
   parameter int N     = 2,
   parameter int W_IDX = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [W_IDX-1:0] start,
   output logic [N-1:0]     gnt
);

   // Walk upward from start with wrap; the first requester seen wins
   always_comb begin
      int   idx;
      logic found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(start) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard3_ahb_arbiter.sv
// N-port to one AHB-Lite master arbiter with panic priority,
// address-phase hold under wait states and data-phase routing.
module hazard3_ahb_arbiter
   import hazard3_bus_pkg::*;
#(
   parameter int         N_PORTS       = 2,
   parameter int         W_ADDR        = 32,
   parameter int         W_DATA        = 32,
   parameter int         ARB_MODE      = 0,
   parameter logic [3:0] HPROT_DEFAULT = 4'b0010
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic [N_PORTS-1:0]         port_aph_req,
   input  logic [N_PORTS-1:0]         port_aph_panic,
   input  logic [N_PORTS-1:0]         port_aph_excl,
   input  logic [N_PORTS*W_ADDR-1:0]  port_haddr,
   input  logic [N_PORTS*3-1:0]       port_hsize,
   input  logic [N_PORTS-1:0]         port_hwrite,
   input  logic [N_PORTS*W_DATA-1:0]  port_wdata,

   output logic [N_PORTS-1:0]         port_aph_ready,
   output logic [N_PORTS-1:0]         port_dph_ready,
   output logic [N_PORTS-1:0]         port_dph_err,
   output logic [N_PORTS-1:0]         port_dph_exokay,
   output logic [W_DATA-1:0]          port_rdata,

   output logic [W_ADDR-1:0]          haddr,
   output logic                       hwrite,
   output logic [1:0]                 htrans,
   output logic [2:0]                 hsize,
   output logic [2:0]                 hburst,
   output logic [3:0]                 hprot,
   output logic                       hmastlock,
   output logic                       hexcl,
   output logic [W_DATA-1:0]          hwdata,
   input  logic                       hready,
   input  logic                       hresp,
   input  logic                       hexokay,
   input  logic [W_DATA-1:0]          hrdata
);

   localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [N_PORTS-1:0] panic_req;
   logic [N_PORTS-1:0] panic_gnt;
   logic [N_PORTS-1:0] norm_gnt;
   logic [N_PORTS-1:0] arb_gnt;
   logic [N_PORTS-1:0] gnt;
   logic [W_IDX-1:0]   norm_start;
   logic [W_IDX-1:0]   gnt_idx;

   logic [W_ADDR-1:0]  sel_addr;
   logic [2:0]         sel_size;
   logic               sel_write;
   logic               sel_excl;

   logic [W_IDX-1:0]   rr_ptr_q, rr_ptr_d;
   logic               hold_q, hold_d;
   logic [N_PORTS-1:0] hold_gnt_q, hold_gnt_d;
   logic [W_ADDR-1:0]  hold_addr_q, hold_addr_d;
   logic [2:0]         hold_size_q, hold_size_d;
   logic               hold_write_q, hold_write_d;
   logic               hold_excl_q, hold_excl_d;
   logic [N_PORTS-1:0] dph_owner_q, dph_owner_d;

   assign panic_req  = port_aph_req & port_aph_panic;
   assign norm_start = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

   hazard3_rr_priority_sel #(
      .N     (N_PORTS),
      .W_IDX (W_IDX)
   ) u_sel_panic (
      .req   (panic_req),
      .start ('0),
      .gnt   (panic_gnt)
   );

   hazard3_rr_priority_sel #(
      .N     (N_PORTS),
      .W_IDX (W_IDX)
   ) u_sel_norm (
      .req   (port_aph_req),
      .start (norm_start),
      .gnt   (norm_gnt)
   );

   // Grant: held port wins outright, then panic, then normal arbitration
   always_comb begin
      arb_gnt = (|panic_req) ? panic_gnt : norm_gnt;
      if (hold_q)
         gnt = hold_gnt_q;
      else if (rst)
         gnt = '0;
      else
         gnt = arb_gnt;
   end

   // Mux the live address-phase attributes of the granted port
   always_comb begin
      sel_addr  = '0;
      sel_size  = '0;
      sel_write = 1'b0;
      sel_excl  = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (gnt[k]) begin
            sel_addr  = port_haddr[k*W_ADDR +: W_ADDR];
            sel_size  = port_hsize[k*3 +: 3];
            sel_write = port_hwrite[k];
            sel_excl  = port_aph_excl[k];
            gnt_idx   = W_IDX'(k);
         end
      end
   end

   // Bus address phase; a stalled NSEQ replays its captured attributes
   always_comb begin
      htrans = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
      if (hold_q) begin
         haddr  = hold_addr_q;
         hsize  = hold_size_q;
         hwrite = hold_write_q;
         hexcl  = hold_excl_q;
      end else begin
         haddr  = sel_addr;
         hsize  = sel_size;
         hwrite = sel_write;
         hexcl  = sel_excl;
      end
   end

   assign hburst    = HBURST_SINGLE;
   assign hmastlock = 1'b0;
   assign hprot     = HPROT_DEFAULT;

   assign port_aph_ready = gnt & {N_PORTS{hready}};

   // Next state for hold, round-robin pointer and data-phase owner
   always_comb begin
      int nxt;
      nxt          = int'(gnt_idx) + 1;
      if (nxt >= N_PORTS) nxt = 0;
      hold_d       = (|gnt) && !hready;
      hold_gnt_d   = gnt;
      hold_addr_d  = haddr;
      hold_size_d  = hsize;
      hold_write_d = hwrite;
      hold_excl_d  = hexcl;
      rr_ptr_d     = rr_ptr_q;
      dph_owner_d  = dph_owner_q;
      if (hready) begin
         dph_owner_d = gnt;
         if (|gnt) rr_ptr_d = W_IDX'(nxt);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         hold_q       <= 1'b0;
         hold_gnt_q   <= '0;
         hold_addr_q  <= '0;
         hold_size_q  <= '0;
         hold_write_q <= 1'b0;
         hold_excl_q  <= 1'b0;
         dph_owner_q  <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         hold_q       <= hold_d;
         hold_gnt_q   <= hold_gnt_d;
         hold_addr_q  <= hold_addr_d;
         hold_size_q  <= hold_size_d;
         hold_write_q <= hold_write_d;
         hold_excl_q  <= hold_excl_d;
         dph_owner_q  <= dph_owner_d;
      end
   end

   assign port_dph_ready  = dph_owner_q & {N_PORTS{hready}};
   assign port_dph_err    = dph_owner_q & {N_PORTS{hresp}};
   assign port_dph_exokay = dph_owner_q & {N_PORTS{hexokay}};
   assign port_rdata      = hrdata;

   // Write data follows the data-phase owner, zero when none
   always_comb begin
      hwdata = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (dph_owner_q[k]) hwdata = port_wdata[k*W_DATA +: W_DATA];
      end
   end

endmodule

// File: doc/hazard3_ahb_arbiter.md
HAZARD3_AHB_ARBITER -- requirements
Module: hazard3_ahb_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesting core-side ports (range 1..8).
REQ-002 SHALL have parameter W_ADDR, default 32, address width.
REQ-003 SHALL have parameter W_DATA, default 32, data width.
REQ-004 SHALL have parameter ARB_MODE, default 0, 0 = fixed priority (port 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter HPROT_DEFAULT, default 4'b0010, value driven on hprot.
REQ-006 SHALL provide clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL provide port_aph_req  input  N_PORTS  per-port address-phase request.
REQ-009 SHALL provide port_aph_panic  input  N_PORTS  per-port urgent request; raises priority.
REQ-010 SHALL provide port_aph_excl  input  N_PORTS  per-port exclusive-access flag.
REQ-011 SHALL provide port_haddr / port_hsize / port_hwrite  input  N_PORTS*W_ADDR / N_PORTS*3 / N_PORTS  packed per-port address-phase attributes, port k at slice k.
REQ-012 SHALL provide port_wdata  input  N_PORTS*W_DATA  packed per-port write data.
REQ-013 SHALL provide port_aph_ready / port_dph_ready / port_dph_err / port_dph_exokay  output  N_PORTS each  per-port handshake returns.
REQ-014 SHALL provide port_rdata  output  W_DATA  hrdata broadcast to all ports.
REQ-015 SHALL provide AHB-Lite master: haddr, hwrite, htrans[1:0], hsize[2:0], hburst[2:0], hprot[3:0], hmastlock, hexcl, hwdata out; hready, hresp, hexokay, hrdata in.

Function
REQ-016 SHALL drive htrans = NSEQ when a grant exists, else IDLE; haddr/hsize/hwrite/hexcl from granted port, else zero.
REQ-017 SHALL select the grant combinationally: lowest-index panicking requester first; else by ARB_MODE among requesters.
REQ-018 SHALL, in round-robin mode, search upward from rr_ptr with wrap from N_PORTS-1 to 0; rr_ptr <= granted index +1 (mod N_PORTS) on each accepted address phase (grant && hready).
REQ-019 SHALL hold the grant: if a NSEQ was presented while hready low, the same port stays granted with identical attributes until hready high, ignoring new higher-priority/panic requests.
REQ-020 SHALL assert port_aph_ready[k] = hready && granted port k; at most one bit set.
REQ-021 SHALL register a one-hot data-phase owner dph_owner, loaded with accepted grant (or zero) when hready high, held when hready low.
REQ-022 SHALL assert port_dph_ready[k] = hready && dph_owner[k].
REQ-023 SHALL assert port_dph_err[k] = dph_owner[k] && hresp, not gated by hready (two-phase error visible in first cycle).
REQ-024 SHALL assert port_dph_exokay[k] = dph_owner[k] && hexokay.
REQ-025 SHALL drive hwdata from port_wdata of dph_owner; zero when dph_owner is zero.
REQ-026 SHALL tie hburst = 3'b000, hmastlock = 0, hprot = HPROT_DEFAULT.
REQ-027 SHALL, with N_PORTS = 1, reduce to pass-through equivalent to a single direct port (no extra latency).
REQ-028 SHALL add zero cycles of address-phase latency: request and NSEQ in same cycle.
REQ-029 SHALL, if a port deasserts port_aph_req while held under REQ-019, keep htrans = NSEQ (hold overrides requester).

Reset
REQ-030 SHALL, while rst high, clear dph_owner, rr_ptr and hold flag to 0; outputs then htrans = IDLE, all port_* handshakes 0, hwdata 0.
REQ-031 SHALL, on rst asserted mid-transfer, abandon the data phase immediately; no port_dph_ready pulse after release.

Structure
REQ-032 SHALL take HTRANS_IDLE/HTRANS_NSEQ and ARB_MODE encodings from the shared package hazard3_bus_pkg.
REQ-033 SHALL implement priority selection in one sub-module hazard3_rr_priority_sel (request vector, start index -> one-hot grant).

Verification
REQ-034 SHALL cover: N_PORTS=2, ARB_MODE=0, both request every cycle, hready=1 -> port 0 granted every cycle, port 1 starved.
REQ-035 SHALL cover: N_PORTS=3, ARB_MODE=1, all request, hready=1 -> grants 0,1,2,0,1,2 on consecutive cycles.
REQ-036 SHALL cover: port 1 NSEQ haddr=0x2000_0010, hready low 3 cycles while port 0 asserts panic -> haddr/htrans unchanged 3 cycles, port 0 granted next.
REQ-037 SHALL cover: port 0 write 0xDEADBEEF accepted, data phase hresp=1 two cycles (hready 0 then 1) -> port_dph_err[0] both cycles, port_dph_ready[0] second only, hwdata 0xDEADBEEF throughout.
REQ-038 SHALL cover: rst pulsed during wait-stated data phase -> htrans IDLE, dph_owner 0, no port_dph_ready after release.
REQ-039 SHALL cover: exclusive load port 1, hexokay=1 in data phase -> port_dph_exokay = 2'b10, hexcl=1 in its address phase.
